// File: rtl/countdown8bit_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// active-low seven-segment glyph table.
package countdown8bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/countdown8bit_hex_display.sv
// Purely combinational nibble-to-seven-segment decoder.
module hex_display
  import countdown8bit_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7(nib_i);

endmodule

// File: rtl/countdown8bit.sv
// Loadable 8-bit countdown timer with start/pause control, a prescaled tick,
// and two seven-segment digit outputs.
module countdown8bit
  import countdown8bit_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [7:0] LOAD_VAL,
  input  logic       START,
  input  logic       PAUSE,
  output logic [7:0] COUNT,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic       RUNNING,
  output logic       DONE
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t          state_q, state_d;
  logic [7:0]      count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      count_q <= 8'h00;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
    end
  end

  // Priority per cycle: LOAD, then PAUSE, then START, then the prescaler tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          count_d = LOAD_VAL;
        end else if (START) begin
          if (count_q != 8'h00) begin
            state_d = ST_RUN;
            presc_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (LOAD) begin
          count_d = LOAD_VAL;
          presc_d = '0;
          state_d = (LOAD_VAL == 8'h00) ? ST_DONE : ST_RUN;
        end else if (PAUSE) begin
          state_d = ST_PAUSED;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (count_q != 8'h00) count_d = count_q - 8'd1;
          if (count_q <= 8'h01) state_d = ST_DONE;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSED: begin
        if (LOAD) begin
          count_d = LOAD_VAL;
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (START) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (LOAD) begin
          count_d = LOAD_VAL;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign COUNT   = count_q;
  assign RUNNING = (state_q == ST_RUN);
  assign DONE    = (state_q == ST_DONE);

  hex_display u_hex0 (
    .nib_i (count_q[3:0]),
    .seg_o (HEX0)
  );

  hex_display u_hex1 (
    .nib_i (count_q[7:4]),
    .seg_o (HEX1)
  );

endmodule

// File: tb/tb_countdown8bit.sv
// Directed bench for countdown8bit with a 4-cycle prescaler.
module tb_countdown8bit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOAD = 1'b0;
  logic [7:0] LOAD_VAL = 8'h00;
  logic       START = 1'b0;
  logic       PAUSE = 1'b0;
  logic [7:0] COUNT;
  logic [6:0] HEX0, HEX1;
  logic       RUNNING, DONE;

  int n_checks = 0;
  int n_fail   = 0;

  countdown8bit #(.TICK_DIV(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .START    (START),
    .PAUSE    (PAUSE),
    .COUNT    (COUNT),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .RUNNING  (RUNNING),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse(input logic ld, input logic [7:0] val, input logic st, input logic pa);
    LOAD = ld; LOAD_VAL = val; START = st; PAUSE = pa;
    @(posedge CLK);
    #1;
    LOAD = 1'b0; START = 1'b0; PAUSE = 1'b0;
  endtask

  initial begin
    // Reset
    cycles(1);
    check_eq("rst_count", COUNT, 8'h00);
    check_eq("rst_hex0", HEX0, 7'b1000000);
    check_eq("rst_hex1", HEX1, 7'b1000000);
    check_eq("rst_running", RUNNING, 1'b0);
    check_eq("rst_done", DONE, 1'b0);
    RST = 1'b0;

    // Load 3 and count down to zero
    pulse(1'b1, 8'h03, 1'b0, 1'b0);
    check_eq("ld3_count", COUNT, 8'h03);
    check_eq("ld3_hex0", HEX0, 7'b0110000);
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("st_running", RUNNING, 1'b1);
    cycles(3);
    check_eq("pre_tick1", COUNT, 8'h03);
    cycles(1);
    check_eq("tick1_count", COUNT, 8'h02);
    check_eq("tick1_hex0", HEX0, 7'b0100100);
    cycles(4);
    check_eq("tick2_count", COUNT, 8'h01);
    cycles(3);
    check_eq("pre_tick3_running", RUNNING, 1'b1);
    cycles(1);
    check_eq("tick3_count", COUNT, 8'h00);
    check_eq("tick3_done", DONE, 1'b1);
    check_eq("tick3_running", RUNNING, 1'b0);
    cycles(6);
    check_eq("nowrap_count", COUNT, 8'h00);
    check_eq("nowrap_done", DONE, 1'b1);

    // Pause and resume
    pulse(1'b1, 8'hA5, 1'b0, 1'b0);
    check_eq("ldA5_done", DONE, 1'b0);
    check_eq("ldA5_count", COUNT, 8'hA5);
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    cycles(2);
    pulse(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("pause_running", RUNNING, 1'b0);
    pulse(1'b0, 8'h00, 1'b0, 1'b1);
    cycles(9);
    check_eq("paused_count", COUNT, 8'hA5);
    check_eq("paused_hex1", HEX1, 7'b0001000);
    check_eq("paused_hex0", HEX0, 7'b0010010);
    check_eq("paused_done", DONE, 1'b0);
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("resume_running", RUNNING, 1'b1);
    cycles(1);
    check_eq("resume_plus1", COUNT, 8'hA5);
    cycles(1);
    check_eq("resume_plus2", COUNT, 8'hA4);

    // Load zero while running
    pulse(1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("run_ld0_done", DONE, 1'b1);
    check_eq("run_ld0_count", COUNT, 8'h00);
    check_eq("run_ld0_running", RUNNING, 1'b0);

    // Start with zero count from idle
    pulse(1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("idle0_done", DONE, 1'b0);
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("st0_done", DONE, 1'b1);
    check_eq("st0_running", RUNNING, 1'b0);
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    pulse(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("done_ign_done", DONE, 1'b1);
    check_eq("done_ign_running", RUNNING, 1'b0);
    pulse(1'b1, 8'h10, 1'b0, 1'b0);
    check_eq("done_ld_done", DONE, 1'b0);
    check_eq("done_ld_count", COUNT, 8'h10);
    check_eq("done_ld_hex1", HEX1, 7'b1111001);
    check_eq("done_ld_hex0", HEX0, 7'b1000000);

    // Reset mid-run, then LOAD+START together
    pulse(1'b1, 8'h41, 1'b0, 1'b0);
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    cycles(4);
    check_eq("run40_count", COUNT, 8'h40);
    check_eq("run40_running", RUNNING, 1'b1);
    RST = 1'b1;
    pulse(1'b1, 8'h77, 1'b1, 1'b0);
    RST = 1'b0;
    check_eq("midrst_count", COUNT, 8'h00);
    check_eq("midrst_running", RUNNING, 1'b0);
    check_eq("midrst_hex1", HEX1, 7'b1000000);
    pulse(1'b1, 8'h22, 1'b1, 1'b0);
    check_eq("ldst_count", COUNT, 8'h22);
    check_eq("ldst_running", RUNNING, 1'b0);
    cycles(5);
    check_eq("ldst_idle_hold", COUNT, 8'h22);

    // Pause coincident with tick
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    cycles(3);
    check_eq("pt_pre", COUNT, 8'h22);
    pulse(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("pt_count", COUNT, 8'h22);
    check_eq("pt_running", RUNNING, 1'b0);
    cycles(4);
    check_eq("pt_hold", COUNT, 8'h22);
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    cycles(1);
    check_eq("pt_resume_tick", COUNT, 8'h21);

    // Load while paused returns to idle with a fresh prescaler
    pulse(1'b0, 8'h00, 1'b0, 1'b1);
    pulse(1'b1, 8'h07, 1'b0, 1'b0);
    check_eq("pld_count", COUNT, 8'h07);
    check_eq("pld_running", RUNNING, 1'b0);
    check_eq("pld_done", DONE, 1'b0);
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    cycles(3);
    check_eq("pld_pre", COUNT, 8'h07);
    cycles(1);
    check_eq("pld_tick", COUNT, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
